// File: rtl/phase_report_tx.sv
// UART transmitter for one phase report frame: HEADER, s0..s7 and, when
// PHASE_TX_CHECKSUM_EN is defined, an XOR checksum byte. 8N1, no inter-byte gap.
module phase_report_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [63:0] phase_in,
    output logic        busy,
    output logic        done,
    output logic        rs232_tx
);

    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
`ifdef PHASE_TX_CHECKSUM_EN
    localparam logic [3:0] LastByte = 4'd9;
`else
    localparam logic [3:0] LastByte = 4'd8;
`endif

    // StNext is the byte-advance decision; it is resolved on the STOP exit
    // edge and is never held in the state register.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StNext
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  byte_q, byte_d;
    logic [63:0] snap_q, snap_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic        bit_end;
    logic [2:0]  bit_nxt;
    logic [2:0]  byte_sel;
    logic [7:0]  cur_byte;

    assign bit_end  = (baud_q == BaudLast);
    assign bit_nxt  = bit_q + 3'd1;
    assign byte_sel = 3'(byte_q - 4'd1);

`ifdef PHASE_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            csum = csum ^ snap_q[8*i +: 8];
        end
    end
`endif

    always_comb begin
        cur_byte = HEADER;
        if (byte_q >= 4'd1 && byte_q <= 4'd8) begin
            cur_byte = snap_q[{byte_sel, 3'b000} +: 8];
        end
`ifdef PHASE_TX_CHECKSUM_EN
        else if (byte_q == 4'd9) begin
            cur_byte = csum;
        end
`endif
    end

    // tx_d is the line level for the cycle after this edge, so the serial
    // output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (start) begin
                    snap_d  = phase_in;
                    state_d = StStart;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    byte_d  = 4'd0;
                    tx_d    = 1'b0;
                end
            end

            StStart: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            StStop: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (byte_q == LastByte) begin
                        state_d = StIdle;
                        byte_d  = 4'd0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            StNext: begin
                state_d = StIdle;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                byte_d  = 4'd0;
                tx_d    = 1'b1;
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            byte_q  <= 4'd0;
            snap_q  <= 64'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign rs232_tx = tx_q;

endmodule

// File: tb/tb_phase_report_tx.sv
// Scoreboard bench for phase_report_tx: stimulus pushes expected bytes, a UART
// monitor decodes the line and pops/compares. Honours PHASE_TX_CHECKSUM_EN.
module tb_phase_report_tx;

    localparam int unsigned Cpb = 4;
`ifdef PHASE_TX_CHECKSUM_EN
    localparam int Nb = 10;
`else
    localparam int Nb = 9;
`endif
    localparam int FrameLen = Nb * 10 * Cpb;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b0;
    logic        start    = 1'b0;
    logic [63:0] phase_in = 64'd0;
    logic        busy;
    logic        done;
    logic        rs232_tx;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    int         t0_q[$];
    int         end_q[$];

    phase_report_tx #(
        .CLKS_PER_BIT(Cpb),
        .HEADER      (8'hAA)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .phase_in(phase_in),
        .busy    (busy),
        .done    (done),
        .rs232_tx(rs232_tx)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: header, phase bytes low to high, optional XOR of phase bytes.
    function automatic void push_frame(input logic [63:0] p);
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(p[8*i +: 8]);
            x = x ^ p[8*i +: 8];
        end
        if (Nb == 10) exp_q.push_back(x);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [63:0] p);
        phase_in = p;
        start    = 1'b1;
        push_frame(p);
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        chk("tx_after_start", {busy, rs232_tx}, 2'b10);
    endtask

    task automatic wait_done(input bit check_busy);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < FrameLen + 50 && !seen; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) n++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (check_busy) chk("busy_len", 64'(n), 64'(FrameLen));
        @(posedge sys_clk);
        #1;
    endtask

    // Called on the first negedge where the line is low.
    task automatic decode_frame();
        int t0;
        logic [9:0] bits;
        logic       held;
        logic       side_ok;
        logic [7:0] e;
        t0 = cyc;
        for (int b = 0; b < Nb; b++) begin
            bits    = 10'd0;
            held    = 1'b1;
            side_ok = 1'b1;
            for (int k = 0; k < 10; k++) begin
                for (int s = 0; s < int'(Cpb); s++) begin
                    if (b != 0 || k != 0 || s != 0) @(negedge sys_clk);
                    if (sys_rst) return;
                    if (s == 0) bits[k] = rs232_tx;
                    else if (rs232_tx !== bits[k]) held = 1'b0;
                    if (busy !== 1'b1 || done !== 1'b0) side_ok = 1'b0;
                end
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", bits[8:1]);
            end else begin
                e = exp_q.pop_front();
                chk("byte", 64'({held, side_ok, bits}), 64'({1'b1, 1'b1, 1'b1, e, 1'b0}));
            end
        end
        @(negedge sys_clk);
        if (sys_rst) return;
        chk("done_edge", 64'({done, busy, rs232_tx}), 64'(3'b101));
        chk("frame_len", 64'(cyc - t0), 64'(FrameLen));
        t0_q.push_back(t0);
        end_q.push_back(cyc);
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && rs232_tx === 1'b0) decode_frame();
        end
    end

    initial begin
        logic [63:0] p;
        int base;
        int n0;

        #1 sys_rst = 1'b1;
        tick(2);
        chk("reset_state", 64'({rs232_tx, busy, done}), 64'(3'b100));
        sys_rst = 1'b0;
        tick(2);
        chk("idle_line", 64'({rs232_tx, busy}), 64'(2'b10));

        send_frame(64'h0807060504030201);
        wait_done(1'b1);
        tick(3);
        send_frame(64'h0);
        wait_done(1'b1);
        tick(2);

        // Snapshot isolation and start ignored while busy.
        base = done_cnt;
        send_frame(64'h1122334455667788);
        tick(4);
        phase_in = '1;
        tick(95);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(1'b0);
        tick(20);
        chk("single_done", 64'(done_cnt - base), 64'd1);

        // Reset mid-frame.
        p = {$urandom, $urandom};
        send_frame(p);
        tick(149);
        #2;
        sys_rst = 1'b1;
        exp_q.delete();
        base = done_cnt;
        #1;
        chk("rst_async", 64'({rs232_tx, busy, done}), 64'(3'b100));
        tick(3);
        sys_rst = 1'b0;
        tick(45);
        chk("rst_no_resume", 64'({rs232_tx, busy, 32'(done_cnt - base)}), 64'({2'b10, 32'd0}));
        send_frame({$urandom, $urandom});
        wait_done(1'b1);

        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(0, 5));
            send_frame({$urandom, $urandom});
            wait_done(1'b1);
        end

        // Start held high: three frames, one idle-high cycle between them.
        tick(3);
        p = {$urandom, $urandom};
        phase_in = p;
        for (int i = 0; i < 3; i++) push_frame(p);
        n0    = end_q.size();
        start = 1'b1;
        repeat (3 * FrameLen + 3) @(posedge sys_clk);
        #1;
        start = 1'b0;
        tick(30);
        chk("b2b_frames", 64'(end_q.size() - n0), 64'd3);
        if (end_q.size() - n0 >= 3) begin
            for (int i = 0; i < 2; i++) begin
                chk("b2b_gap", 64'(t0_q[n0 + i + 1] - end_q[n0 + i]), 64'd1);
            end
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_report_tx.md
PHASE_REPORT_TX -- requirements
Module: phase_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning sys_clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter HEADER, default 8'hAA, meaning the first byte of every frame.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to send one report frame, sampled on each sys_clk edge.
REQ-006 SHALL have port phase_in  input  64  eight phase bytes s0..s7, with s0 = phase_in[7:0] and s7 = phase_in[63:56].
REQ-007 SHALL have port busy  output  1  high while a frame is in flight.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the last stop bit completes.
REQ-009 SHALL have port rs232_tx  output  1  UART serial line, idle high.

Function
REQ-010 SHALL transmit a frame of HEADER, then s0..s7 in that order, then the checksum byte when the configuration macro is defined.
REQ-011 SHALL compute the checksum as the bitwise XOR of s0..s7; HEADER is excluded.
REQ-012 SHALL format each byte as 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), with each bit held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL place no idle gap between bytes: the next start bit follows the previous stop bit directly.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP and NEXT; NEXT is a zero-width decision state that is merged into the STOP exit.
REQ-015 SHALL capture phase_in into an internal snapshot register when start=1 in IDLE; later changes to phase_in SHALL NOT affect the frame.
REQ-016 SHALL, once start=1 is seen in IDLE at edge N, drive busy=1 and rs232_tx=0 (the start bit of HEADER) from edge N+1.
REQ-017 SHALL use a bit counter that counts 0..7 in DATA, a byte index that counts 0..9 (0..8 when the checksum is compiled out), and a baud counter that counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit.
REQ-018 SHALL, at the end of the last stop bit, return to IDLE, drop busy and pulse done=1 for exactly one cycle on that same edge.
REQ-019 SHALL ignore start while busy=1, with no queueing and no restart.
REQ-020 SHALL, when start=1 in the same cycle that done pulses, not accept it; a new frame may be accepted no earlier than the following cycle.
REQ-021 SHALL make the frame duration exactly (bytes x 10 x CLKS_PER_BIT) cycles from the first start-bit cycle to the done edge.
REQ-022 SHALL hold rs232_tx high at all times in IDLE.

Reset
REQ-023 SHALL, while sys_rst=1, force rs232_tx=1, busy=0, done=0, FSM=IDLE, all counters=0 and snapshot=0, asynchronously.
REQ-024 SHALL, on reset mid-frame, abort the frame immediately and not resume it; the first start in IDLE after reset release begins a fresh frame.
REQ-025 SHALL drive no output glitch low on rs232_tx at reset release.

Configuration
REQ-026 SHALL, when macro PHASE_TX_CHECKSUM_EN is defined, send 10-byte frames (HEADER, s0..s7, checksum).
REQ-027 SHALL, when PHASE_TX_CHECKSUM_EN is undefined, send 9-byte frames (HEADER, s0..s7) and synthesize no checksum logic.

Verification (CLKS_PER_BIT=4, checksum enabled unless stated)
REQ-028 SHALL cover this scenario: phase_in=64'h0807060504030201, start pulse -> bytes AA,01,02,03,04,05,06,07,08,08 decoded LSB-first; done pulses 400 cycles after the first start bit.
REQ-029 SHALL cover this scenario: phase_in=0, start pulse -> bytes AA,00x8,00; busy high for exactly 400 cycles; rs232_tx=0 on the cycle after start.
REQ-030 SHALL cover this scenario: start at cycle 0, phase_in changed to all-FF at cycle 5, and start re-pulsed at cycle 100 -> frame still carries the cycle-0 values; exactly one done pulse is produced.
REQ-031 SHALL cover this scenario: sys_rst asserted at cycle 150 mid-frame -> rs232_tx=1 and busy=0 in the same cycle; start at cycle 200 -> a complete new frame follows.
REQ-032 SHALL cover this scenario: start held high continuously -> back-to-back frames, each separated by exactly one idle-high cycle (the done cycle plus the accept cycle).
REQ-033 SHALL cover this scenario: PHASE_TX_CHECKSUM_EN undefined, phase_in=64'h0807060504030201 -> bytes AA,01..08; done at 360 cycles.
